// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the serial-pattern detection controller:
// FSM state encoding and default sizing constants.
// Optional build macro used by the design: SEQ_DET_OVERLAP_EN.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if
// Flow-controlled serial input and hit output of the detection controller.
//   x_valid / x / x_ready        : serial bit stream, accepted on valid & ready
//   hit_valid / hit_ready        : detection event, consumed on valid & ready
// modport master : source of bits / consumer of hits (testbench, upstream)
// modport slave  : the detection controller
interface seq_det_ctrl_if;
  logic x_valid;
  logic x;
  logic x_ready;
  logic hit_valid;
  logic hit_ready;

  modport master (output x_valid, output x, input x_ready,
                  input hit_valid, output hit_ready);
  modport slave  (input x_valid, input x, output x_ready,
                  output hit_valid, input hit_ready);
endinterface

// File: rtl/seq_hist_shift.sv
// seq_hist_shift
// Bit history shift register with a saturating fill counter.
//   clk, rst_n : clock, synchronous active-low reset
//   shift_en   : shift bit_in into hist[0] and bump fill
//   bit_in     : incoming serial bit
//   clr        : clear hist and fill (wins over shift_en)
//   hist       : most recent bits, hist[0] = newest
//   fill       : number of valid bits in hist, saturates at MAX_LEN
module seq_hist_shift #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clr,
  output logic [MAX_LEN-1:0] hist,
  output logic [LEN_W-1:0]   fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= {hist[MAX_LEN-2:0], bit_in};
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
// Programmable serial-pattern detector. Scans a valid/ready bit stream for
// a configured pattern of 1..MAX_LEN bits, reports each detection through a
// hit valid/ready handshake and keeps a saturating count of consumed hits.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_wr/pattern/len    : config write (accepted only in IDLE, len 1..MAX_LEN)
//   cfg_err               : one-cycle pulse when a config write is rejected
//   enable                : run request
//   cnt_clr               : clear hit_count (wins over a coincident hit)
//   sif                   : serial input and hit handshake (slave modport)
//   hit_count             : completed hit handshakes, saturating
//   busy                  : controller not in IDLE
// Build macro SEQ_DET_OVERLAP_EN: keep history on a match so overlapping
// occurrences are reported; undefined, each match needs len fresh bits.
//
// state | meaning
// IDLE  | stopped, config writes allowed
// RUN   | accepting bits and comparing
// HIT   | detection pending, input stalled until hit_ready
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_err,
  input  logic               enable,
  input  logic               cnt_clr,
  seq_det_ctrl_if.slave      sif,
  output logic [CNT_W-1:0]   hit_count,
  output logic               busy
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] hist, hist_nxt, mask;
  logic [LEN_W-1:0]   fill, fill_nxt;
  logic               accept, match, handshake, hist_clr, cfg_ok;

  seq_hist_shift #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .bit_in   (sif.x),
    .clr      (hist_clr),
    .hist     (hist),
    .fill     (fill)
  );

  assign accept    = (state == RUN) && sif.x_valid;
  assign handshake = (state == HIT) && sif.hit_ready;
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_MAX);

  // Compare against the history as it will look after this bit is shifted in.
  assign hist_nxt = {hist[MAX_LEN-2:0], sif.x};
  assign fill_nxt = (fill >= LEN_MAX) ? LEN_MAX : fill + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) mask[i] = (i < int'(len));
  end

  assign match = accept && (fill_nxt >= len) &&
                 (((hist_nxt ^ pattern) & mask) == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && len != '0) state_nxt = RUN;
      RUN:     if (match) state_nxt = HIT;
               else if (!enable) state_nxt = IDLE;
      HIT:     if (sif.hit_ready) state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // History is dropped whenever the controller stops; without the overlap
  // build it is also dropped on every match so the next hit needs fresh bits.
`ifdef SEQ_DET_OVERLAP_EN
  assign hist_clr = (state != IDLE) && (state_nxt == IDLE);
`else
  assign hist_clr = ((state != IDLE) && (state_nxt == IDLE)) ||
                    ((state == RUN) && (state_nxt == HIT));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pattern       <= '0;
      len           <= '0;
      hit_count     <= '0;
      cfg_err       <= 1'b0;
      busy          <= 1'b0;
      sif.x_ready   <= 1'b0;
      sif.hit_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != IDLE);
      sif.x_ready   <= (state_nxt == RUN);
      sif.hit_valid <= (state_nxt == HIT);
      cfg_err       <= cfg_wr && !((state == IDLE) && cfg_ok);
      if (cfg_wr && (state == IDLE) && cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
      end
      if (cnt_clr) hit_count <= '0;
      else if (handshake && (hit_count != '1)) hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl
// Self-checking bench for seq_det_ctrl (built with CNT_W=2 so counter
// saturation is reachable). A reference model on the accepted bit stream
// pushes the index of every bit that should complete a match; each hit
// handshake pops and compares. Honours SEQ_DET_OVERLAP_EN.
module tb_seq_det_ctrl;

  localparam int CW = 2;
`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [7:0]    cfg_pattern = '0;
  logic [3:0]    cfg_len = '0;
  logic          cfg_err;
  logic          enable = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] hit_count;
  logic          busy;

  seq_det_ctrl_if bus();

  seq_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(CW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_err     (cfg_err),
    .enable      (enable),
    .cnt_clr     (cnt_clr),
    .sif         (bus),
    .hit_count   (hit_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int exp_q[$];
  logic [7:0] ref_hist = '0;
  logic [7:0] ref_pat = '0;
  int ref_fill = 0;
  int ref_len = 0;

  typedef struct {
    logic xv;
    logic xb;
    logic exp_xr;
    logic exp_hv;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, observed at negedge where the inputs
  // and registered outputs that the next posedge will act on are stable.
  always @(negedge clk) begin
    logic [7:0] nh;
    logic [7:0] msk;
    int nf;
    bit m;
    if (rst_n) begin
      if (bus.x_valid && bus.x_ready) begin
        acc_cnt++;
        nh  = {ref_hist[6:0], bus.x};
        nf  = (ref_fill < 8) ? ref_fill + 1 : 8;
        msk = 8'hFF >> (8 - ref_len);
        m   = (nf >= ref_len) && (((nh ^ ref_pat) & msk) == 8'h00);
        if (m) begin
          exp_q.push_back(acc_cnt);
          ref_hist = OVL ? nh : 8'h00;
          ref_fill = OVL ? nf : 0;
        end else if (!enable) begin
          ref_hist = 8'h00;
          ref_fill = 0;
        end else begin
          ref_hist = nh;
          ref_fill = nf;
        end
      end else if (bus.x_ready && !enable) begin
        ref_hist = 8'h00;
        ref_fill = 0;
      end
      if (bus.hit_valid && bus.hit_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_hit: got hit after bit %0d, expected none", acc_cnt);
        end else begin
          chk("sb_hit_bit_index", acc_cnt, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    ref_hist = '0;
    ref_fill = 0;
    ref_pat  = '0;
    ref_len  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_wr = 1'b0;
    enable = 1'b0;
    cnt_clr = 1'b0;
    bus.x_valid = 1'b0;
    bus.x = 1'b0;
    bus.hit_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit exp_err);
    cfg_wr = 1'b1;
    cfg_pattern = pat;
    cfg_len = len;
    cyc();
    cfg_wr = 1'b0;
    chk("cfg_err_pulse", cfg_err, exp_err);
    if (!exp_err) begin
      ref_pat = pat;
      ref_len = int'(len);
    end
    cyc();
    chk("cfg_err_one_cycle", cfg_err, 0);
  endtask

  task automatic send(input logic b);
    bit ok;
    ok = 1'b0;
    bus.x_valid = 1'b1;
    bus.x = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.x_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no x_ready in 20 cycles, expected acceptance");
    end
    cyc();
    bus.x_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = OVL ? '{1'b0, 1'b0, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0};

    bus.x_valid = 1'b0;
    bus.x = 1'b0;
    bus.hit_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_hit_valid", bus.hit_valid, 0);
    chk("rst_x_ready", bus.x_ready, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);

    // Pattern 1010 against stream 101010, one row per clock.
    do_cfg(8'h0A, 4'd4, 1'b0);
    enable = 1'b1;
    bus.hit_ready = 1'b1;
    cyc();
    for (int i = 0; i < 9; i++) begin
      bus.x_valid = tbl[i].xv;
      bus.x = tbl[i].xb;
      @(negedge clk);
      chk($sformatf("t1_x_ready_row%0d", i), bus.x_ready, tbl[i].exp_xr);
      chk($sformatf("t1_hit_valid_row%0d", i), bus.hit_valid, tbl[i].exp_hv);
      cyc();
    end
    bus.x_valid = 1'b0;
    @(negedge clk);
    chk("t1_hit_count", hit_count, OVL ? 2 : 1);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Backpressure on a 0110 match.
    do_reset();
    do_cfg(8'h06, 4'd4, 1'b0);
    enable = 1'b1;
    cyc();
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    bus.x_valid = 1'b1;
    bus.x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hit_valid_held", bus.hit_valid, 1);
      chk("bp_x_ready_low", bus.x_ready, 0);
      chk("bp_count_zero", hit_count, 0);
      cyc();
    end
    bus.x_valid = 1'b0;
    bus.hit_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("bp_count_one", hit_count, 1);
    chk("bp_x_ready_back", bus.x_ready, 1);
    chk("bp_hit_valid_low", bus.hit_valid, 0);

    // Config writes rejected in RUN and for illegal lengths.
    cyc();
    do_cfg(8'hFF, 4'd2, 1'b1);
    enable = 1'b0;
    cyc();
    @(negedge clk);
    chk("cfg_stop_busy", busy, 0);
    chk("cfg_stop_x_ready", bus.x_ready, 0);
    cyc();
    do_cfg(8'h01, 4'd0, 1'b1);
    do_cfg(8'h01, 4'd9, 1'b1);
    enable = 1'b1;
    cyc();
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    cyc();
    cyc();
    @(negedge clk);
    chk("cfg_old_pattern_count", hit_count, 2);
    chk("cfg_queue_empty", exp_q.size(), 0);

    // Enable dropped mid-pattern clears history.
    do_reset();
    do_cfg(8'h0A, 4'd4, 1'b0);
    enable = 1'b1;
    bus.hit_ready = 1'b1;
    cyc();
    send(1'b1); send(1'b0);
    enable = 1'b0;
    cyc();
    @(negedge clk);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_x_ready", bus.x_ready, 0);
    cyc();
    enable = 1'b1;
    cyc();
    send(1'b1); send(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_drop_no_hit", bus.hit_valid, 0);
      cyc();
    end
    chk("en_drop_count", hit_count, 0);

    // Saturation with a 1-bit pattern, then clear against a handshake.
    do_reset();
    do_cfg(8'h01, 4'd1, 1'b0);
    enable = 1'b1;
    bus.hit_ready = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) send(1'b1);
    cyc();
    cyc();
    @(negedge clk);
    chk("sat_count", hit_count, 3);
    cyc();
    bus.hit_ready = 1'b0;
    send(1'b1);
    cnt_clr = 1'b1;
    bus.hit_ready = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins_count", hit_count, 0);

    // Reset while a hit is pending.
    cyc();
    send(1'b1);
    cyc();
    bus.hit_ready = 1'b0;
    send(1'b1);
    @(negedge clk);
    chk("rst_hit_pending", bus.hit_valid, 1);
    chk("rst_hit_prior_count", hit_count, 1);
    cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_hit_dropped", bus.hit_valid, 0);
    chk("rst_hit_count_zero", hit_count, 0);
    chk("rst_hit_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    model_clear();
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_pattern_len_cleared_idle", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
